// File: rtl/icache_refill.sv
// icache_refill: fetches one instruction-cache line from memory, beat by beat, on a miss
// Ports:
//   clk, arst (sync, active-high)          clock and reset
//   i_start, i_miss_addr                   miss request and missed byte address
//   o_busy                                 refill in progress
//   o_mem_req, o_mem_addr                  beat read request, held until acknowledged
//   i_mem_ack, i_mem_rdata, i_mem_err      beat acknowledge, data and bus error
//   o_line, o_line_addr                    assembled line and its line-aligned address
//   o_cache_we                             one-cycle line write strobe
//   o_fault                                one-cycle instruction access fault
// Build option: ICACHE_CRITICAL_WORD_FIRST_EN starts at the missed word and wraps.
module icache_refill #(
    parameter int BLOCK_WIDTH = 512,
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
    output logic                   o_busy,
    output logic                   o_mem_req,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_ack,
    input  logic [WORD_SIZE-1:0]   i_mem_rdata,
    input  logic                   i_mem_err,
    output logic [BLOCK_WIDTH-1:0] o_line,
    output logic [ADDR_WIDTH-1:0]  o_line_addr,
    output logic                   o_cache_we,
    output logic                   o_fault
);
    localparam int WORD_COUNT = BLOCK_WIDTH / WORD_SIZE;
    localparam int IDX_W      = $clog2(WORD_COUNT);
    localparam int BYTE_W     = $clog2(WORD_SIZE / 8);
    localparam int OFF_W      = IDX_W + BYTE_W;

    typedef enum logic [1:0] {IDLE, FETCH, FILL, FAULT} state_t;

    state_t           state;
    logic [IDX_W-1:0] beat_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] next_idx;
    logic             last_beat;
    logic             unused_ok;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign start_idx = i_miss_addr[OFF_W-1:BYTE_W];
`else
    assign start_idx = '0;
`endif
    // Word index wraps naturally because WORD_COUNT is a power of two.
    assign next_idx  = word_idx + IDX_W'(1);
    assign last_beat = beat_cnt == IDX_W'(WORD_COUNT - 1);
    // Offset bits of the miss address only matter for the starting word, if at all.
    assign unused_ok = ^i_miss_addr[OFF_W-1:0];

    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            word_idx    <= '0;
            o_busy      <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_addr  <= '0;
            o_line      <= '0;
            o_line_addr <= '0;
            o_cache_we  <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    state       <= FETCH;
                    beat_cnt    <= '0;
                    word_idx    <= start_idx;
                    o_busy      <= 1'b1;
                    o_mem_req   <= 1'b1;
                    o_line_addr <= {i_miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    o_mem_addr  <= {i_miss_addr[ADDR_WIDTH-1:OFF_W], start_idx, {BYTE_W{1'b0}}};
                end
                FETCH: if (i_mem_ack) begin
                    if (i_mem_err) begin
                        state     <= FAULT;
                        o_mem_req <= 1'b0;
                        o_fault   <= 1'b1;
                    end else begin
                        o_line[word_idx*WORD_SIZE +: WORD_SIZE] <= i_mem_rdata;
                        word_idx <= next_idx;
                        beat_cnt <= beat_cnt + IDX_W'(1);
                        if (last_beat) begin
                            state      <= FILL;
                            o_mem_req  <= 1'b0;
                            o_cache_we <= 1'b1;
                        end else begin
                            o_mem_addr <= {o_line_addr[ADDR_WIDTH-1:OFF_W], next_idx, {BYTE_W{1'b0}}};
                        end
                    end
                end
                FILL, FAULT: begin
                    state      <= IDLE;
                    o_busy     <= 1'b0;
                    o_cache_we <= 1'b0;
                    o_fault    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: randomized refills checked against a line/word reference model
module tb_icache_refill;
    logic         clk = 1'b0;
    logic         arst, i_start, i_mem_ack, i_mem_err;
    logic [31:0]  i_miss_addr, i_mem_rdata, o_mem_addr, o_line_addr;
    logic         o_busy, o_mem_req, o_cache_we, o_fault;
    logic [511:0] o_line;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [31:0]  mem_w [16];
    logic [31:0]  line_base;

    always #5 clk = ~clk;

    icache_refill dut (
        .clk(clk), .arst(arst), .i_start(i_start), .i_miss_addr(i_miss_addr),
        .o_busy(o_busy), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err),
        .o_line(o_line), .o_line_addr(o_line_addr), .o_cache_we(o_cache_we), .o_fault(o_fault)
    );

    function automatic logic [511:0] exp_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = mem_w[i];
        return l;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One refill of the line holding addr. wait_n idle cycles precede every ack.
    // err_beat >= 0 raises a bus error on that beat; rst_beat >= 0 resets after that beat;
    // poke pulses i_start with a foreign address mid-refill; probe exercises an idle ack.
    task automatic refill(input logic [31:0] addr, input int wait_n, input bit ramp,
                          input int err_beat, input int rst_beat, input bit poke, input bit probe);
        int          first;
        logic [31:0] d, exp_addr;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        first = int'(addr[5:2]);
`else
        first = 0;
`endif
        d = 0;
        i_start = 1'b1;
        i_miss_addr = addr;
        @(negedge clk);
        i_start = 1'b0;
        i_miss_addr = $urandom;
        line_base = addr & 32'hFFFF_FFC0;
        check("busy_start", o_busy, 1);
        check("line_addr_start", o_line_addr, line_base);
        for (int k = 0; k < 16; k++) begin
            exp_addr = line_base + 32'(((first + k) % 16) * 4);
            for (int w = 0; w <= wait_n; w++) begin
                check("mem_req", o_mem_req, 1);
                check("mem_addr", o_mem_addr, exp_addr);
                check("we_fetch", o_cache_we, 0);
                if (w == wait_n) begin
                    d = ramp ? 32'h100 + 32'(k) : $urandom;
                    i_mem_ack = 1'b1;
                    i_mem_rdata = d;
                    i_mem_err = (k == err_beat);
                    if (poke && k == 3) begin
                        i_start = 1'b1;
                        i_miss_addr = 32'hDEAD_0000;
                    end
                end else begin
                    i_mem_rdata = $urandom;
                end
                @(negedge clk);
                i_mem_ack = 1'b0;
                i_mem_err = 1'b0;
                i_start = 1'b0;
            end
            if (k == err_beat) begin
                check("fault_pulse", o_fault, 1);
                check("we_fault", o_cache_we, 0);
                check("busy_fault", o_busy, 1);
                check("req_fault", o_mem_req, 0);
                @(negedge clk);
                check("fault_end", o_fault, 0);
                check("busy_after_fault", o_busy, 0);
                check("we_after_fault", o_cache_we, 0);
                return;
            end
            mem_w[(first + k) % 16] = d;
            if (k == rst_beat) begin
                arst = 1'b1;
                @(negedge clk);
                arst = 1'b0;
                for (int i = 0; i < 16; i++) mem_w[i] = 0;
                line_base = 0;
                check("req_rst", o_mem_req, 0);
                check("busy_rst", o_busy, 0);
                check("line_rst", o_line, exp_line());
                check("line_addr_rst", o_line_addr, line_base);
                check("we_rst", o_cache_we, 0);
                @(negedge clk);
                check("we_after_rst", o_cache_we, 0);
                check("busy_after_rst", o_busy, 0);
                return;
            end
        end
        check("we_fill", o_cache_we, 1);
        check("req_fill", o_mem_req, 0);
        check("fault_fill", o_fault, 0);
        check("busy_fill", o_busy, 1);
        check("line_fill", o_line, exp_line());
        check("line_addr_fill", o_line_addr, line_base);
        @(negedge clk);
        check("we_once", o_cache_we, 0);
        check("busy_idle", o_busy, 0);
        if (probe) begin
            i_mem_ack = 1'b1;
            i_mem_rdata = $urandom;
            @(negedge clk);
            i_mem_ack = 1'b0;
            check("line_held", o_line, exp_line());
            check("line_addr_held", o_line_addr, line_base);
            check("req_idle_ack", o_mem_req, 0);
        end
    endtask

    initial begin
        arst = 1'b1;
        i_start = 1'b1;
        i_miss_addr = 32'h0000_1040;
        i_mem_ack = 1'b0;
        i_mem_err = 1'b0;
        i_mem_rdata = 0;
        for (int i = 0; i < 16; i++) mem_w[i] = 0;
        line_base = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_req", o_mem_req, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_we", o_cache_we, 0);
        check("rst_fault", o_fault, 0);
        check("rst_line", o_line, 0);
        check("rst_line_addr", o_line_addr, 0);
        arst = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        check("start_in_rst_ignored", o_busy, 0);
        refill(32'h0000_1040, 0, 1'b1, -1, -1, 1'b0, 1'b1);
        refill(32'h0000_2034, 0, 1'b1, -1, -1, 1'b0, 1'b0);
        refill(32'h0000_3ABC, 3, 1'b0, -1, -1, 1'b0, 1'b1);
        refill(32'h0000_4010, 0, 1'b0, 5, -1, 1'b0, 1'b0);
        refill(32'h0000_5000, 1, 1'b0, -1, 7, 1'b0, 1'b0);
        refill(32'h0000_6008, 0, 1'b0, -1, -1, 1'b1, 1'b1);
        for (int r = 0; r < 8; r++)
            refill($urandom, int'($urandom_range(0, 2)), 1'b0, -1, -1, (r % 2) == 1, (r % 3) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
